// File: rtl/pong_vga_renderer.sv
// pong_vga_renderer
// Generates VGA sync timing from the pixel clock, paces the game loop with a
// once-per-frame screenEnd pulse, and draws a square ball over a flat
// background. Ball position is sampled once per frame so the image never tears.
// Every output is registered from the same counter state, so all outputs
// describe the same pixel, one clock after the counters reach it.

module pong_vga_renderer #(
    parameter int          H_VISIBLE  = 640,
    parameter int          H_FRONT    = 16,
    parameter int          H_SYNC     = 96,
    parameter int          H_BACK     = 48,
    parameter int          V_VISIBLE  = 480,
    parameter int          V_FRONT    = 10,
    parameter int          V_SYNC     = 2,
    parameter int          V_BACK     = 33,
    parameter int          BALL_SIZE  = 8,
    parameter logic [11:0] BALL_COLOR = 12'hFFF,
    parameter logic [11:0] BG_COLOR   = 12'h000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] ball_x,
    input  logic [31:0] ball_y,
    output logic        hSync,
    output logic        vSync,
    output logic        screenEnd,
    output logic        active,
    output logic [9:0]  x,
    output logic [8:0]  y,
    output logic [11:0] rgb
);

    // Timing landmarks, sized to the counters so every compare is same-width.
    localparam logic [9:0] H_LAST     = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_LAST     = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_LAST    = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_LAST    = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic [10:0] BALL_W    = 11'(BALL_SIZE);
    localparam logic [9:0]  BALL_H    = 10'(BALL_SIZE);

    logic [9:0]  r_hcount;
    logic [9:0]  r_vcount;
    logic [9:0]  r_bx;
    logic [8:0]  r_by;

    logic        w_h_last;
    logic        w_v_last;
    logic        w_frame_end;
    logic [10:0] w_bx_end;
    logic [9:0]  w_by_end;
    logic        w_in_ball;
    logic        w_active;

    assign w_h_last    = (r_hcount == H_LAST);
    assign w_v_last    = (r_vcount == V_LAST);
    assign w_frame_end = w_h_last && w_v_last;

    // Ball extents are one bit wider than the position so a ball near the
    // right/bottom edge is clipped instead of wrapping to the left/top edge.
    assign w_bx_end  = {1'b0, r_bx} + BALL_W;
    assign w_by_end  = {1'b0, r_by} + BALL_H;
    assign w_in_ball = (r_hcount >= r_bx) && ({1'b0, r_hcount} < w_bx_end) &&
                       (r_vcount >= {1'b0, r_by}) && (r_vcount < w_by_end);
    assign w_active  = (r_hcount < H_VIS) && (r_vcount < V_VIS);

    // Raster position: hcount sweeps each line, vcount advances on line wrap.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hcount <= '0;
            r_vcount <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // block sees the pre-edge counter values on the same clock.
            if (w_h_last) begin
                r_hcount <= '0;
                r_vcount <= w_v_last ? '0 : r_vcount + 10'd1;
            end else begin
                r_hcount <= r_hcount + 10'd1;
            end
        end
    end

    // Shadow the ball position on the last blanking pixel of each frame.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_bx <= '0;
            r_by <= '0;
        end else if (w_frame_end) begin
            r_bx <= ball_x[9:0];
            r_by <= ball_y[8:0];
        end
    end

    // Register every output from the same counter state so they stay aligned.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hSync     <= 1'b1;
            vSync     <= 1'b1;
            screenEnd <= 1'b0;
            active    <= 1'b0;
            x         <= '0;
            y         <= '0;
            rgb       <= '0;
        end else begin
            hSync     <= !((r_hcount >= HS_FIRST) && (r_hcount <= HS_LAST));
            vSync     <= !((r_vcount >= VS_FIRST) && (r_vcount <= VS_LAST));
            screenEnd <= (r_hcount == 10'd0) && (r_vcount == V_VIS);
            active    <= w_active;
            x         <= r_hcount;
            y         <= r_vcount[8:0];
            rgb       <= w_active ? (w_in_ball ? BALL_COLOR : BG_COLOR) : 12'h000;
        end
    end

endmodule

// File: tb/tb_pong_vga_renderer.sv
// tb_pong_vga_renderer
// Runs the renderer with a scaled-down raster (56x37 total, 40x30 visible) so
// many frames fit in a short run. Stimulus pushes one expected frame summary
// (ball pixel count and bounding box) per frame into a scoreboard; a monitor
// checks per-pixel timing/colour rules and pops a summary at each screenEnd.

module tb_pong_vga_renderer;

    localparam int HV = 40, HF = 4, HS = 6, HB = 6;
    localparam int VV = 30, VF = 2, VS = 2, VB = 3;
    localparam int HT = HV + HF + HS + HB;     // 56
    localparam int VT = VV + VF + VS + VB;     // 37
    localparam int FRAME = HT * VT;            // 2072
    localparam int FIRST_SE = VV * HT + 1;     // 1681
    localparam logic [11:0] BALLC = 12'hF0A;
    localparam logic [11:0] BGC   = 12'h123;

    logic        clock;
    logic        reset;
    logic [31:0] ball_x;
    logic [31:0] ball_y;
    logic        hSync, vSync, screenEnd, active;
    logic [9:0]  x;
    logic [8:0]  y;
    logic [11:0] rgb;

    pong_vga_renderer #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .BALL_SIZE(8), .BALL_COLOR(BALLC), .BG_COLOR(BGC)
    ) dut (
        .clock(clock), .reset(reset), .ball_x(ball_x), .ball_y(ball_y),
        .hSync(hSync), .vSync(vSync), .screenEnd(screenEnd), .active(active),
        .x(x), .y(y), .rgb(rgb)
    );

    initial clock = 1'b0;
    always #20 clock = ~clock;

    typedef struct {
        int cnt;
        int x0;
        int x1;
        int y0;
        int y1;
    } frame_t;

    frame_t sb[$];
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input int c, input int x0, input int x1, input int y0, input int y1);
        frame_t f;
        f.cnt = c; f.x0 = x0; f.x1 = x1; f.y0 = y0; f.y1 = y1;
        sb.push_back(f);
    endtask

    // ---------------- monitor ----------------
    bit         have_prev = 0;
    bit         have_se = 0;
    logic [9:0] px;
    logic [8:0] py;
    int cyc = 0, last_se = 0, pulses = 0;
    int fmt_err, cnt, mnx, mxx, mny, mxy;

    task automatic clear_acc();
        fmt_err = 0; cnt = 0; mnx = 1023; mxx = 0; mny = 511; mxy = 0;
    endtask

    initial clear_acc();

    always @(negedge clock) begin
        if (reset) begin
            have_prev = 0;
            have_se   = 0;
            clear_acc();
        end else begin
            int ex, ey;
            frame_t f;
            cyc++;
            if (have_prev) begin
                ex = (int'(px) == HT - 1) ? 0 : int'(px) + 1;
                ey = (int'(px) == HT - 1) ? ((int'(py) == VT - 1) ? 0 : int'(py) + 1) : int'(py);
                if (int'(x) != ex || int'(y) != ey) fmt_err++;
            end
            have_prev = 1; px = x; py = y;
            if (hSync !== !(int'(x) >= HV + HF && int'(x) < HV + HF + HS)) fmt_err++;
            if (vSync !== !(int'(y) >= VV + VF && int'(y) < VV + VF + VS)) fmt_err++;
            if (active !== (int'(x) < HV && int'(y) < VV)) fmt_err++;
            if (screenEnd !== (x == 10'd0 && int'(y) == VV)) fmt_err++;
            if (!active) begin
                if (rgb !== 12'h000) fmt_err++;
            end else if (rgb === BALLC) begin
                cnt++;
                if (int'(x) < mnx) mnx = int'(x);
                if (int'(x) > mxx) mxx = int'(x);
                if (int'(y) < mny) mny = int'(y);
                if (int'(y) > mxy) mxy = int'(y);
            end else if (rgb !== BGC) begin
                fmt_err++;
            end
            if (screenEnd === 1'b1) begin
                pulses++;
                if (have_se) check("se_period", cyc - last_se, FRAME);
                have_se = 1;
                last_se = cyc;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: frame ended with no expectation queued");
                end else begin
                    f = sb.pop_front();
                    check("ball_pixels", cnt, f.cnt);
                    check("ball_xmin", mnx, f.x0);
                    check("ball_xmax", mxx, f.x1);
                    check("ball_ymin", mny, f.y0);
                    check("ball_ymax", mxy, f.y1);
                    check("pixel_rules", fmt_err, 0);
                end
                clear_acc();
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_se();
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (screenEnd !== 1'b1 && n < 3 * FRAME);
        if (screenEnd !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL se_timeout: no screenEnd within %0d clocks", n);
        end
    endtask

    task automatic wait_y(input int row);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (int'(y) != row && n < 2 * FRAME);
        if (int'(y) != row) begin
            checks++;
            errors++;
            $display("FAIL row_timeout: row %0d not reached, at %0d", row, y);
        end
    endtask

    task automatic set_ball(input logic [31:0] bx, input logic [31:0] by);
        ball_x = bx;
        ball_y = by;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_hSync"}, hSync, 1);
        check({tag, "_vSync"}, vSync, 1);
        check({tag, "_screenEnd"}, screenEnd, 0);
        check({tag, "_active"}, active, 0);
        check({tag, "_x"}, x, 0);
        check({tag, "_y"}, y, 0);
        check({tag, "_rgb"}, rgb, 0);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        set_ball(32'd77, 32'd33);
        repeat (3) @(negedge clock);
        check_reset_outputs("rst");
        push_exp(64, 0, 7, 0, 7);           // shadows cleared: ball at origin
        #5 reset = 1'b0;
        @(posedge clock); #1;
        check("first_x", x, 0);
        check("first_y", y, 0);
        check("first_active", active, 1);
        check("first_rgb", rgb, BALLC);

        wait_se(); set_ball(32'd10, 32'd5);   push_exp(64, 10, 17, 5, 12);
        wait_se(); set_ball(32'd20, 32'd10);  push_exp(64, 20, 27, 10, 17);
        wait_y(15); ball_x = 32'd30;          // mid-frame change must not tear
        wait_se();                            push_exp(64, 30, 37, 10, 17);
        wait_se(); set_ball(32'd36, 32'd26);  push_exp(16, 36, 39, 26, 29);
        wait_se(); set_ball(32'hFFFF_000A, 32'hFFFF_FE03); push_exp(64, 10, 17, 3, 10);
        wait_se(); set_ball(32'd0, 32'd508);  push_exp(0, 1023, 0, 511, 0);
        wait_se(); set_ball(32'd1020, 32'd0); push_exp(0, 1023, 0, 511, 0);
        wait_se(); set_ball(32'd10, 32'd5);   push_exp(64, 10, 17, 5, 12);

        // Abort this frame with an asynchronous reset between clock edges.
        wait_y(20);
        #2 reset = 1'b1;
        #1 check_reset_outputs("async_rst");
        sb.delete();
        push_exp(64, 0, 7, 0, 7);
        repeat (3) @(negedge clock);
        #5 reset = 1'b0;
        n = 0;
        while (n < 2 * FRAME) begin
            @(posedge clock);
            n++;
            #1;
            if (screenEnd === 1'b1) break;
        end
        check("se_after_reset", n, FIRST_SE);
        @(negedge clock);
        set_ball(32'd5, 32'd5); push_exp(64, 5, 12, 5, 12);
        wait_se();
        @(negedge clock);
        check("pulse_total", pulses, 10);
        check("sb_left", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #(40 * 60000);
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

endmodule
